// File: rtl/adc_seq_pkg.sv
// Shared types and defaults for the ADC sample sequencer.
// Holds the sequencer state encoding, the overrun counter width, default
// parameter values and a saturating add helper for the lost-event counter.
package adc_seq_pkg;

  localparam int OVR_CNT_W       = 8;
  localparam int DEF_DATA_W      = 12;
  localparam int DEF_AVG_LOG2    = 2;
  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    WAIT_EOC = 2'd2,
    PUSH     = 2'd3
  } seq_state_e;

  // Add 0..3 lost events to the counter, pinning at all-ones instead of wrapping.
  function automatic logic [OVR_CNT_W-1:0] sat_add(input logic [OVR_CNT_W-1:0] cnt,
                                                   input logic [1:0]           inc);
    logic [OVR_CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(OVR_CNT_W-1){1'b0}}, inc};
    if (sum[OVR_CNT_W]) begin
      sat_add = {OVR_CNT_W{1'b1}};
    end else begin
      sat_add = sum[OVR_CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/adc_avg_accumulator.sv
// Running sum of 2^AVG_LOG2 conversion results.
// The sum is DATA_W+AVG_LOG2 bits wide, so a full set of samples can never
// overflow it. 'last' is high when the next add completes a full set; 'mean'
// is the truncated sum shifted down by AVG_LOG2.
module adc_avg_accumulator
  import adc_seq_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              add,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic              last,
  output logic [DATA_W-1:0] mean
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_d, acc_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next sum/count: clear wins over add so a drop never keeps a stale partial.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = {ACC_W{1'b0}};
      cnt_d = {CNT_W{1'b0}};
    end else if (add) begin
      acc_d = acc_q + ACC_W'(din);
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Sum and sample-count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= {ACC_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_LAST);
  assign mean = DATA_W'(acc_q >> AVG_LOG2);

endmodule

// File: rtl/adc_sample_sequencer.sv
// ADC sample sequencer: one conversion per rising edge of the oscillator tick,
// averages 2^AVG_LOG2 results and offers the mean on a valid/ready port.
// Lost ticks and discarded averages are flagged in overrun/overrun_cnt.
// Optional feature macro: ADC_SEQ_TIMEOUT_EN adds an end-of-conversion
// watchdog that abandons the conversion after TIMEOUT_CYC cycles.
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int AVG_LOG2    = DEF_AVG_LOG2,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 enable,
  output logic                 conv_start,
  input  logic                 adc_eoc,
  input  logic [DATA_W-1:0]    adc_data,
  output logic [DATA_W-1:0]    sample_data,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  output logic [OVR_CNT_W-1:0] overrun_cnt,
  output logic                 timeout_err
);

  seq_state_e state_d, state_q;
  logic tick_q;
  logic rise_s;
  logic conv_start_d, conv_start_q;
  logic [DATA_W-1:0] sample_data_d, sample_data_q;
  logic sample_valid_d, sample_valid_q;
  logic overrun_d, overrun_q;
  logic [OVR_CNT_W-1:0] overrun_cnt_d, overrun_cnt_q;
  logic acc_add, acc_clr, acc_last, push, tick_lost, push_lost;
  logic [DATA_W-1:0] acc_mean;
  logic tmo_hit;

  assign rise_s = tick & ~tick_q;

  adc_avg_accumulator #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_acc (
    .clk   (clk),
    .reset (reset),
    .add   (acc_add),
    .clr   (acc_clr),
    .din   (adc_data),
    .last  (acc_last),
    .mean  (acc_mean)
  );

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt_d, tmo_cnt_q;
  logic timeout_err_d, timeout_err_q;

  // Watchdog counts cycles spent in WAIT_EOC, restarting on every entry.
  always_comb begin
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q | tmo_hit;
    if (state_q == WAIT_EOC) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end else begin
      tmo_cnt_d = {TMO_W{1'b0}};
    end
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q     <= {TMO_W{1'b0}};
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Sequencer next state and the accumulator/push controls it issues.
  always_comb begin
    state_d   = state_q;
    acc_add   = 1'b0;
    acc_clr   = 1'b0;
    push      = 1'b0;
    tick_lost = 1'b0;
    tmo_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        // A partial average does not survive a disabled period.
        acc_clr = ~enable;
        if (rise_s && enable) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        tick_lost = rise_s & enable;
        state_d   = WAIT_EOC;
      end
      WAIT_EOC: begin
        tick_lost = rise_s & enable;
        if (adc_eoc) begin
          acc_add = 1'b1;
          if (acc_last) begin
            state_d = PUSH;
          end else begin
            state_d = IDLE;
          end
`ifdef ADC_SEQ_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          acc_clr = 1'b1;
          state_d = IDLE;
`endif
        end else begin
          state_d = WAIT_EOC;
        end
      end
      PUSH: begin
        tick_lost = rise_s & enable;
        push      = 1'b1;
        acc_clr   = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register, start pulse and lost-event bookkeeping.
  always_comb begin
    conv_start_d   = (state_d == START);
    sample_data_d  = sample_data_q;
    sample_valid_d = sample_valid_q;
    push_lost      = 1'b0;
    if (push) begin
      if (sample_valid_q && !sample_ready) begin
        // Downstream still holds the previous mean: keep it, drop the new one.
        push_lost = 1'b1;
      end else begin
        sample_data_d  = acc_mean;
        sample_valid_d = 1'b1;
      end
    end else if (sample_valid_q && sample_ready) begin
      sample_valid_d = 1'b0;
    end else begin
      sample_valid_d = sample_valid_q;
    end
    overrun_d     = overrun_q | tick_lost | push_lost;
    overrun_cnt_d = sat_add(overrun_cnt_q, {1'b0, tick_lost} + {1'b0, push_lost});
  end

  // State, edge-detect and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      tick_q         <= 1'b0;
      conv_start_q   <= 1'b0;
      sample_data_q  <= {DATA_W{1'b0}};
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      overrun_cnt_q  <= {OVR_CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      tick_q         <= tick;
      conv_start_q   <= conv_start_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      overrun_cnt_q  <= overrun_cnt_d;
    end
  end

  assign conv_start   = conv_start_q;
  assign sample_data  = sample_data_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign overrun_cnt  = overrun_cnt_q;

endmodule
